// File: rtl/const_mac_stream.sv
// Streaming constant-coefficient MAC: one rounded, optionally saturated
// dot product per frame of TAPS signed samples, valid/ready on both sides.
module const_mac_stream #(
  parameter int IW = 16,
  parameter int CW = 16,
  parameter int TAPS = 4,
  parameter logic [TAPS*CW-1:0] COEFFS = {16'sd1, 16'sd5, -16'sd2, 16'sd30},
  parameter int OW = 32,
  parameter int SHIFT = 0,
  parameter int SAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_ovf
);

  localparam int PW   = IW + CW;
  localparam int TIW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int ACCW = PW + $clog2(TAPS) + 1;
  localparam int RW   = ACCW + 1;

  logic                   en;
  logic                   accept;
  logic [TIW-1:0]         tap_idx;
  logic                   last_tap;
  logic signed [CW-1:0]   coeff;
  logic signed [PW-1:0]   prod;

  logic                   p_valid;
  logic signed [PW-1:0]   p_prod;
  logic                   p_first;
  logic                   p_last;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;

  logic signed [RW-1:0]   wide;
  logic signed [RW-1:0]   r;
  logic signed [OW-1:0]   res;
  logic                   ovf;

  // A stalled output freezes every stage, so one enable drives them all.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign last_tap = (tap_idx == TIW'(TAPS - 1));

  always_comb begin
    coeff = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (tap_idx == TIW'(k)) coeff = COEFFS[k*CW +: CW];
    end
  end

  assign prod = PW'(in_data) * PW'(coeff);
  assign sum  = (p_first ? '0 : acc) + ACCW'(p_prod);
  assign wide = RW'(sum);

  generate
    if (SHIFT > 0) begin : g_round
      assign r = (wide + RW'(1 <<< (SHIFT - 1))) >>> SHIFT;
    end else begin : g_noround
      assign r = wide;
    end
  endgenerate

  generate
    if (OW >= RW) begin : g_fit
      assign res = OW'(r);
      assign ovf = 1'b0;
    end else begin : g_narrow
      logic [RW-OW:0] hi;
      logic           fits;
      // r fits in OW bits exactly when all bits from OW-1 upward agree.
      assign hi   = r[RW-1:OW-1];
      assign fits = (&hi) || !(|hi);
      assign ovf  = !fits;
      if (SAT != 0) begin : g_sat
        assign res = fits ? r[OW-1:0]
                   : (r[RW-1] ? {1'b1, {(OW-1){1'b0}}}
                              : {1'b0, {(OW-1){1'b1}}});
      end else begin : g_wrap
        assign res = r[OW-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_idx   <= '0;
      p_valid   <= 1'b0;
      p_prod    <= '0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        tap_idx <= last_tap ? '0 : tap_idx + TIW'(1);
      end
      if (en) begin
        p_valid   <= accept;
        p_prod    <= prod;
        p_first   <= (tap_idx == '0);
        p_last    <= last_tap;
        out_valid <= p_valid && p_last;
        if (p_valid) begin
          acc <= p_last ? '0 : sum;
        end
        if (p_valid && p_last) begin
          out_data <= res;
          out_ovf  <= ovf;
        end
      end
    end
  end

endmodule
